// File: rtl/col_sched_pkg.sv
// col_sched_pkg: shared types and constants for the column scheduler
package col_sched_pkg;
   typedef enum logic {IDLE, SWEEP} state_t;
   localparam int OVR_W = 16;
   localparam int SEC_W_MAX = 16;
   typedef struct packed {
      logic                 valid;
      logic                 mode;
      logic [SEC_W_MAX-1:0] sector;
   } pend_t;
endpackage

// File: rtl/col_window_calc.sv
// col_window_calc: sector+mode -> first column and beat count of a sweep
// ports: sector/mode in; start (first column), count (beats in sweep) out
module col_window_calc #(
   parameter int NUM_COLS = 64,
   parameter int WINDOW   = 8
) (
   input  logic [$clog2(NUM_COLS)-1:0] sector,
   input  logic                        mode,
   output logic [$clog2(NUM_COLS)-1:0] start,
   output logic [$clog2(NUM_COLS):0]   count
);
   localparam int SW = $clog2(NUM_COLS);
   localparam int CW = SW + 1;
   localparam logic [SW-1:0] HALF = SW'(WINDOW / 2);
   // SW-bit subtraction wraps modulo NUM_COLS
   assign start = mode ? sector - HALF : sector;
   assign count = mode ? CW'(WINDOW) : CW'(NUM_COLS);
endmodule

// File: rtl/col_sched.sv
// col_sched: streams LED column indices per angle step, with a one-deep pending slot
// ports: clk_in/rst_in (async active-high); theta_in/theta_valid_in/mode_in angle step;
//   col_index_out/col_valid_out/col_ready_in/col_last_out column stream; busy_out;
//   overrun_count_out counts overwritten pending steps when COL_SCHED_STATS_EN is defined, else 0
module col_sched
   import col_sched_pkg::*;
#(
   parameter int THETA_RES = 27,
   parameter int NUM_COLS  = 64,
   parameter int WINDOW    = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [THETA_RES-1:0]        theta_in,
   input  logic                        theta_valid_in,
   input  logic                        mode_in,
   output logic [$clog2(NUM_COLS)-1:0] col_index_out,
   output logic                        col_valid_out,
   input  logic                        col_ready_in,
   output logic                        col_last_out,
   output logic                        busy_out,
   output logic [OVR_W-1:0]            overrun_count_out
);
   localparam int SW = $clog2(NUM_COLS);
   localparam int CW = SW + 1;
   state_t state, n_state;
   pend_t pend, n_pend;
   logic [SW-1:0] sector, calc_sector, start, n_idx;
   logic [CW-1:0] count, rem, n_rem;
   logic calc_mode, acc, fin, load, store, ovr_hit, n_valid, n_last;
   logic unused_bits;
   assign sector = theta_in[THETA_RES-1 -: SW];
   assign unused_bits = ^{theta_in[THETA_RES-SW-1:0], pend.sector[SEC_W_MAX-1:SW]};
   // a waiting step always takes precedence over the live input when sourcing the next sweep
   assign calc_sector = pend.valid ? pend.sector[SW-1:0] : sector;
   assign calc_mode = pend.valid ? pend.mode : mode_in;
   col_window_calc #(.NUM_COLS(NUM_COLS), .WINDOW(WINDOW)) u_calc (
      .sector(calc_sector),
      .mode  (calc_mode),
      .start (start),
      .count (count)
   );
   always_comb begin
      acc = col_valid_out & col_ready_in;
      fin = acc & col_last_out;
      load = (state == IDLE & theta_valid_in) | (fin & (pend.valid | theta_valid_in));
      // a step landing on the final beat with an empty slot starts the next sweep directly
      store = theta_valid_in & state == SWEEP & !(fin & !pend.valid);
      ovr_hit = store & pend.valid & !fin;
      n_state = load ? SWEEP : (fin ? IDLE : state);
      n_idx = load ? start : (acc ? col_index_out + 1'b1 : col_index_out);
      n_rem = load ? count : (acc ? rem - 1'b1 : rem);
      n_valid = load | (col_valid_out & !fin);
      n_last = load ? (count == CW'(1)) : (acc ? rem == CW'(2) : col_last_out);
      n_pend = store ? pend_t'({1'b1, mode_in, SEC_W_MAX'(sector)}) : ((fin & pend.valid) ? '0 : pend);
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         pend <= '0;
         col_index_out <= '0;
         rem <= '0;
         col_valid_out <= 1'b0;
         col_last_out <= 1'b0;
      end else begin
         state <= n_state;
         pend <= n_pend;
         col_index_out <= n_idx;
         rem <= n_rem;
         col_valid_out <= n_valid;
         col_last_out <= n_last;
      end
   end
   assign busy_out = state == SWEEP;
`ifdef COL_SCHED_STATS_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) overrun_count_out <= '0;
      else if (ovr_hit && overrun_count_out != '1) overrun_count_out <= overrun_count_out + OVR_W'(1);
   end
`else
   logic unused_ovr;
   assign unused_ovr = ovr_hit;
   assign overrun_count_out = '0;
`endif
endmodule

// File: tb/tb_col_sched.sv
// tb_col_sched: scoreboard bench for col_sched (NUM_COLS=64, WINDOW=8 and WINDOW=1 builds)
module tb_col_sched;
   logic clk = 0, rst = 1;
   logic [26:0] theta = 0;
   logic tv = 0, mode = 0, ready = 1, tv1 = 0, ready1 = 1;
   logic [5:0] idx, idx1;
   logic valid, last, busy, valid1, last1, busy1;
   logic [15:0] ovr, ovr1;
   int tests = 0, fails = 0;
   int q[$];
   int e;
   bit hold_v = 0;
   logic [5:0] hold_i;
   logic hold_l;
`ifdef COL_SCHED_STATS_EN
   localparam int EXP_OVR = 1;
`else
   localparam int EXP_OVR = 0;
`endif
   always #5 clk = ~clk;
   col_sched #(.THETA_RES(27), .NUM_COLS(64), .WINDOW(8)) dut (
      .clk_in(clk), .rst_in(rst), .theta_in(theta), .theta_valid_in(tv), .mode_in(mode),
      .col_index_out(idx), .col_valid_out(valid), .col_ready_in(ready), .col_last_out(last),
      .busy_out(busy), .overrun_count_out(ovr)
   );
   col_sched #(.THETA_RES(27), .NUM_COLS(64), .WINDOW(1)) dut1 (
      .clk_in(clk), .rst_in(rst), .theta_in(theta), .theta_valid_in(tv1), .mode_in(mode),
      .col_index_out(idx1), .col_valid_out(valid1), .col_ready_in(ready1), .col_last_out(last1),
      .busy_out(busy1), .overrun_count_out(ovr1)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic push_sweep(input int s, input bit m);
      int st = m ? ((s - 4) & 63) : s;
      int n = m ? 8 : 64;
      for (int i = 0; i < n; i++) q.push_back(((st + i) & 63) | ((i == n - 1) ? 256 : 0));
   endtask
   task automatic pulse(input int s, input bit m);
      theta = {6'(s), 21'($urandom)};
      mode = m;
      tv = 1;
      @(posedge clk);
      #1 tv = 0;
   endtask
   task automatic drain(input string tag, input int exp_n, input bit toggle);
      int n = 0;
      int k = 0;
      bit done = 0;
      for (int t = 0; t < 2000 && !done; t++) begin
         ready = toggle ? (k % 3 == 0) : 1'b1;
         @(negedge clk);
         if (valid) n++;
         else begin
            done = 1;
            chk({tag, "_bubble"}, q.size(), 0);
         end
         @(posedge clk);
         #1 k++;
      end
      ready = 1;
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_cycles"}, n, exp_n);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_last"}, last, 0);
   endtask
   initial begin
      int n;
      bit found;
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (hold_v) begin
                  chk("hold_idx", idx, hold_i);
                  chk("hold_last", last, hold_l);
               end
               if (valid && ready) begin
                  tests++;
                  assert (q.size() > 0) else begin
                     fails++;
                     $error("FAIL extra_beat: got index %0d expected no beat", idx);
                  end
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     chk("beat_idx", idx, e & 63);
                     chk("beat_last", last, e >> 8);
                  end
               end
               hold_v = valid && !ready;
               hold_i = idx;
               hold_l = last;
            end else hold_v = 0;
         end
      join_none
      #12;
      chk("rst_idx", idx, 0);
      chk("rst_valid", valid, 0);
      chk("rst_last", last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_valid1", valid1, 0);
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;
      push_sweep(2, 1);
      pulse(2, 1);
      chk("lat_valid", valid, 1);
      chk("lat_idx", idx, 62);
      chk("lat_busy", busy, 1);
      drain("win2", 8, 0);
      push_sweep(40, 0);
      pulse(40, 0);
      drain("all40", 64, 0);
      push_sweep(10, 1);
      pulse(10, 1);
      drain("toggle10", 22, 1);
      push_sweep(2, 1);
      pulse(2, 1);
      repeat (7) @(posedge clk);
      #1;
      push_sweep(50, 1);
      pulse(50, 1);
      drain("direct50", 8, 0);
      chk("direct_ovr", ovr, 0);
      push_sweep(2, 1);
      push_sweep(30, 1);
      pulse(2, 1);
      pulse(20, 1);
      pulse(30, 1);
      drain("overrun", 14, 0);
      chk("overrun_cnt", ovr, EXP_OVR);
      push_sweep(60, 0);
      pulse(60, 0);
      found = 0;
      for (int t = 0; t < 100 && !found; t++) begin
         @(negedge clk);
         if (valid && idx == 0) found = 1;
      end
      chk("rst_reach", 32'(found), 1);
      #2 rst = 1;
      #1;
      q.delete();
      chk("mid_rst_idx", idx, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_last", last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ovr", ovr, 0);
      @(negedge clk);
      rst = 0;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         n += int'(valid);
      end
      chk("post_rst_beats", n, 0);
      chk("post_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      theta = {6'd63, 21'($urandom)};
      mode = 1;
      tv1 = 1;
      @(posedge clk);
      #1 tv1 = 0;
      chk("w1_idx", idx1, 63);
      chk("w1_valid", valid1, 1);
      chk("w1_last", last1, 1);
      chk("w1_busy", busy1, 1);
      @(posedge clk);
      #1;
      chk("w1_valid_end", valid1, 0);
      chk("w1_last_end", last1, 0);
      chk("w1_busy_end", busy1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
